// File: rtl/sum_display.sv
// sum_display
//   Converts the 6-bit adder result (0..63) into two BCD digits using a
//   sequential shift-and-add-3 (double dabble) engine, then drives a 4-digit,
//   active-low, time-multiplexed seven-segment display.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous, active-high reset
//   sum        : unsigned adder result, sampled only when a conversion starts
//   bcd        : {tens, ones} of the last completed conversion
//   conv_done  : one-cycle pulse in the cycle bcd takes a new value
//   an         : digit anodes, active-low, an[0] is the rightmost digit
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low, always off
//
// Parameters
//   REFRESH_BITS  : width of the free-running refresh counter; its top two
//                   bits pick the digit being lit
//   BLANK_LEADING : 1 blanks a zero tens digit instead of showing "0"
module sum_display #(
  parameter int REFRESH_BITS  = 16,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sum,
  output logic [7:0] bcd,
  output logic       conv_done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Six shifts move every bit of the 6-bit binary field into the BCD nibbles.
  localparam logic [2:0] LAST_SHIFT = 3'd5;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Converter state
  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  // Working register layout: {tens[3:0], ones[3:0], binary[5:0]}
  logic [13:0] work_q, work_d;
  logic [7:0]  bcd_q, bcd_d;
  logic        done_q, done_d;

  // Display state
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [1:0]              sel;
  logic [3:0]              tens, ones;

  // A nibble that is 5 or more would exceed 9 after the coming doubling, so
  // it is pre-corrected by 3 (the +6 decimal adjust, halved).
  function automatic logic [3:0] add3(input logic [3:0] n);
    logic [3:0] r;
    r = n;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end
    return r;
  endfunction

  // One double-dabble iteration: correct both BCD nibbles, then shift left.
  function automatic logic [13:0] dabble_step(input logic [13:0] w);
    logic [13:0] adj;
    adj = {add3(w[13:10]), add3(w[9:6]), w[5:0]};
    return {adj[12:0], 1'b0};
  endfunction

  // Active-low gfedcba pattern for one decimal digit; non-decimal codes blank.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Converter: IDLE samples sum, SHIFT runs six iterations, DONE publishes.
  // The loop is a fixed 8 cycles and never waits on anything.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        work_d  = {8'h00, sum};
        cnt_d   = 3'd0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        work_d = dabble_step(work_q);
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = work_q[13:6];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      bcd_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // The working register is always reloaded in IDLE before it is used, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  // ---------------------------------------------------------------------
  // Display: free-running refresh counter, digit mux and segment decode.
  // Only the published bcd register feeds the display, so the digits never
  // flicker through intermediate working values.
  // ---------------------------------------------------------------------
  assign sel  = refresh_q[REFRESH_BITS-1 -: 2];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    an_d      = AN_OFF;
    seg_d     = SEG_OFF;
    case (sel)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = decode7(ones);
      end
      2'd1: begin
        if (!(BLANK_LEADING && (tens == 4'd0))) begin
          an_d  = 4'b1101;
          seg_d = decode7(tens);
        end
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      refresh_q <= refresh_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bcd       = bcd_q;
  assign conv_done = done_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_sum_display.sv
module tb_sum_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sum = 6'd45;

  logic [7:0] bcd_b, bcd_n;
  logic       done_b, done_n;
  logic [3:0] an_b, an_n;
  logic [6:0] seg_b, seg_n;
  logic       dp_b, dp_n;

  int ncmp  = 0;
  int nfail = 0;
  int rc    = 0;   // edges since the last reset edge

  typedef struct {
    logic [5:0] s;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  sum_display #(.REFRESH_BITS(4), .BLANK_LEADING(1'b1)) u_blank (
    .clk(clk), .rst(rst), .sum(sum), .bcd(bcd_b), .conv_done(done_b),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  sum_display #(.REFRESH_BITS(4), .BLANK_LEADING(1'b0)) u_noblank (
    .clk(clk), .rst(rst), .sum(sum), .bcd(bcd_n), .conv_done(done_n),
    .an(an_n), .seg(seg_n), .dp(dp_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) rc <= 0;
    else     rc <= rc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("one_anode_blank", 32'($countones(~an_b) <= 1), 32'd1);
    chk("one_anode_noblank", 32'($countones(~an_n) <= 1), 32'd1);
  endtask

  // Number of edges until conv_done is seen high; -1 if it never comes.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_b === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [7:0] ref_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Expected display for a given digit slot, from the digit rules.
  task automatic model_disp(input int slot, input logic [7:0] b, input bit blank,
                            output logic [3:0] ea, output logic [6:0] es);
    ea = 4'b1111;
    es = 7'b1111111;
    if (slot == 0) begin
      ea = 4'b1110;
      es = seg_tab[b[3:0]];
    end else if (slot == 1 && !(blank && b[7:4] == 4'd0)) begin
      ea = 4'b1101;
      es = seg_tab[b[7:4]];
    end
  endtask

  task automatic chk_disp(input logic [7:0] b);
    int slot;
    logic [3:0] ea;
    logic [6:0] es;
    slot = ((rc - 1) % 16) / 4;
    model_disp(slot, b, 1'b1, ea, es);
    chk("an_blank", 32'(an_b), 32'(ea));
    chk("seg_blank", 32'(seg_b), 32'(es));
    model_disp(slot, b, 1'b0, ea, es);
    chk("an_noblank", 32'(an_n), 32'(ea));
    chk("seg_noblank", 32'(seg_n), 32'(es));
  endtask

  task automatic run_display(input logic [5:0] v);
    int n;
    sum = v;
    wait_done(n);
    chk("disp_sync", 32'(n), 32'd8);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk_disp(ref_bcd(int'(v)));
      tick();
    end
    wait_done(n);
    chk("disp_resync", 32'(n > 0), 32'd1);
  endtask

  initial begin
    int n;
    int v;

    tbl[0] = '{6'd9,  8'h09};
    tbl[1] = '{6'd10, 8'h10};
    tbl[2] = '{6'd62, 8'h62};
    tbl[3] = '{6'd63, 8'h63};
    tbl[4] = '{6'd0,  8'h00};
    tbl[5] = '{6'd19, 8'h19};
    tbl[6] = '{6'd55, 8'h55};

    // Reset hold with sum=45
    rst = 1'b1;
    sum = 6'd45;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", 32'(an_b), 32'hF);
      chk("rst_seg", 32'(seg_b), 32'h7F);
      chk("rst_bcd", 32'(bcd_b), 32'h00);
      chk("rst_done", 32'(done_b), 32'd0);
      chk("rst_dp", 32'(dp_b), 32'd1);
    end
    rst = 1'b0;
    wait_done(n);
    chk("first_latency", 32'(n), 32'd8);
    chk("first_bcd", 32'(bcd_b), 32'h45);
    tick();
    chk("done_single_pulse", 32'(done_b), 32'd0);
    chk("bcd_held", 32'(bcd_b), 32'h45);
    wait_done(n);
    chk("resync", 32'(n), 32'd7);

    // Table vectors (at a conv_done sample point: the next edge samples sum)
    for (int i = 0; i < 7; i++) begin
      sum = tbl[i].s;
      wait_done(n);
      chk("tbl_period", 32'(n), 32'd8);
      chk("tbl_bcd", 32'(bcd_b), 32'(tbl[i].exp));
      chk("tbl_bcd_nb", 32'(bcd_n), 32'(tbl[i].exp));
    end

    // Full sweep against the arithmetic model
    for (int s = 0; s < 64; s++) begin
      sum = 6'(s);
      wait_done(n);
      chk("sweep_period", 32'(n), 32'd8);
      chk("sweep_bcd", 32'(bcd_b), 32'(ref_bcd(s)));
    end

    // Random values
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(63, 0));
      sum = 6'(v);
      wait_done(n);
      chk("rand_period", 32'(n), 32'd8);
      chk("rand_bcd", 32'(bcd_b), 32'(ref_bcd(v)));
    end

    // Display multiplexing and leading-zero blanking
    run_display(6'd37);
    run_display(6'd7);
    run_display(6'd60);

    // sum changes two cycles after the sampling edge
    sum = 6'd12;
    tick();
    tick();
    tick();
    sum = 6'd50;
    wait_done(n);
    chk("late_change_latency", 32'(n), 32'd5);
    chk("late_change_bcd", 32'(bcd_b), 32'h12);
    wait_done(n);
    chk("next_conv_period", 32'(n), 32'd8);
    chk("next_conv_bcd", 32'(bcd_b), 32'h50);

    // Reset during the 4th SHIFT cycle of a conversion of 58
    sum = 6'd58;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_done", 32'(done_b), 32'd0);
      chk("abort_bcd", 32'(bcd_b), 32'h00);
      chk("abort_an", 32'(an_b), 32'hF);
    end
    rst = 1'b0;
    wait_done(n);
    chk("abort_no_pulse_latency", 32'(n), 32'd8);
    chk("abort_then_bcd", 32'(bcd_b), 32'h58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sum_display.md
Name: sum_display

Overview:
- Downstream consumer of the 5-bit operand adder's 6-bit result (range 0..63).
- Continuously samples the sum and converts it to two BCD digits with a sequential shift-and-add-3 (double dabble) engine.
- Drives a 4-digit, active-low, time-multiplexed seven-segment display of the kind on the lab board.
- Sits between the adder output and the top-level display pins.

Parameters:
- REFRESH_BITS, 16: width of the free-running refresh counter; its top 2 bits select the digit (2^(REFRESH_BITS-2) cycles per digit).
- BLANK_LEADING, 1: when 1, a zero tens digit is blanked instead of showing "0".

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sum  input  6  unsigned adder result; sampled only at conversion start.
- bcd  output 8  {tens[3:0], ones[3:0]} of the last completed conversion.
- conv_done  output 1  one-cycle pulse when bcd updates.
- an  output 4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  output 7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output 1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (rst=1 at an edge) sets:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - bcd=8'h00, conv_done=0.
  - FSM=IDLE, shift count=0, refresh counter=0.
- Reset mid-conversion aborts it; bcd keeps the reset value 00, and no conv_done pulse occurs for the aborted conversion.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: at the next edge, load a 14-bit working register {tens=0, ones=0, sum}, clear the shift count, go to SHIFT.
  - SHIFT: each cycle, first add 3 to any BCD nibble >= 5, then shift the whole register left by 1 and increment the count. After the 6th shift, go to DONE.
  - DONE: bcd <= working BCD nibbles, conv_done <= 1, go to IDLE.
- Timing: if sum is sampled at edge E, then bcd and conv_done=1 are visible after edge E+7.
  - conv_done drops after edge E+8, which is also the next sample.
  - Conversion period is fixed at 8 cycles; the converter never stalls.
- Changes on sum outside the IDLE sampling edge are ignored until the next sample.
- Results for 0..63: tens 0..6, ones 0..9. The hundreds nibble is not needed and not implemented.
- Refresh counter: free-running, wraps from 2^REFRESH_BITS-1 to 0. sel = counter[REFRESH_BITS-1:REFRESH_BITS-2].
- Digit selection (an/seg registered, one cycle after sel changes):
  - sel=0: an=1110, seg=decode(ones).
  - sel=1: an=1101, seg=decode(tens). If BLANK_LEADING=1 and tens=0, then an=1111 and seg=1111111.
  - sel=2, sel=3: an=1111, seg=1111111 (unused digits blank).
- The display always shows the registered bcd, never intermediate working-register values.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value gives 1111111.
- At most one anode is low in any cycle, including the cycle after reset release.

Test Plan:
- Reset hold 3 cycles with sum=6'd45 → an=1111, seg=1111111, bcd=00, conv_done=0 throughout. Release → bcd=8'h45 and a single conv_done pulse 7 cycles after the first sampling edge.
- Sweep sum 0..63, waiting for conv_done each time → bcd equals the decimal digits of every value (e.g. 9→09, 10→10, 62→62, 63→63); conv_done period exactly 8 cycles.
- REFRESH_BITS=4, sum=6'd37 → an cycles 1110, 1101, 1111, 1111 every 4 cycles. seg=1111000 when an=1110; seg=0110000 when an=1101.
- BLANK_LEADING=1, sum=6'd7 → tens digit slot shows an=1111. Repeat with BLANK_LEADING=0 → an=1101 with seg=1000000.
- Change sum from 12 to 50 two cycles after a sampling edge → that conversion still yields bcd=12; the next conversion yields 50.
- Assert rst during the 4th SHIFT cycle of a conversion of 58 → no conv_done pulse and bcd stays 00. After release, the first result is 58.
